// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with local credit flow control for a shared synchronous FIFO.
// Optional build macro FIFO_ARB_PRIO_EN: requester 0 gets strict priority over a round-robin of the rest.
`timescale 1ns/1ps
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  input  logic                     fifo_full_i,
  input  logic                     fifo_pop_i,
  output logic                     fifo_wr_en_o,
  output logic [WIDTH-1:0]         fifo_wdata_o,
  output logic [CNT_WIDTH-1:0]     credits_o,
  output logic                     stall_o,
  output logic                     err_o
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          N     = int'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    STALL = 2'b10
  } state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]     gnt_d;
  logic                   wr_en_d;
  logic [WIDTH-1:0]       wdata_d;
  logic [CNT_WIDTH-1:0]   credits_d;
  logic                   err_d;

  logic [NUM_REQ-1:0]     elig_c;
  logic [NUM_REQ-1:0]     rr_elig_c;
  logic [PTR_W-1:0]       cand_c;
  logic [PTR_W-1:0]       win_c;
  logic                   found_c;
  logic                   grant_c;

  // The just-granted requester is masked so one held word is never granted twice.
  always_comb begin
    elig_c = req_i & ~gnt_o;
`ifdef FIFO_ARB_PRIO_EN
    rr_elig_c = elig_c & ~NUM_REQ'(1);
`else
    rr_elig_c = elig_c;
`endif
  end

  // Winner search: requester 0 first when prioritised, then first eligible after the pointer.
  always_comb begin
    found_c = 1'b0;
    win_c   = ptr_q;
    cand_c  = ptr_q;
`ifdef FIFO_ARB_PRIO_EN
    if (elig_c[0]) begin
      found_c = 1'b1;
      win_c   = '0;
    end
`endif
    for (int i = 1; i <= N; i++) begin
      cand_c = PTR_W'((int'(ptr_q) + i) % N);
      if (!found_c && rr_elig_c[cand_c]) begin
        found_c = 1'b1;
        win_c   = cand_c;
      end
    end
  end

  // Next-state, next-output and credit accounting.
  always_comb begin
    state_d   = IDLE;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    wr_en_d   = 1'b0;
    wdata_d   = fifo_wdata_o;
    credits_d = credits_o;
    err_d     = err_o;

    grant_c = found_c && (credits_o != '0) && !fifo_full_i;

    if (grant_c) begin
      state_d       = GRANT;
      gnt_d[win_c]  = 1'b1;
      wr_en_d       = 1'b1;
      wdata_d       = wdata_i[int'(win_c)*WIDTH +: WIDTH];
`ifdef FIFO_ARB_PRIO_EN
      if (win_c != '0) ptr_d = win_c;
`else
      ptr_d = win_c;
`endif
    end else if (elig_c != '0) begin
      state_d = STALL;
    end

    if (grant_c && !fifo_pop_i) begin
      credits_d = credits_o - CNT_WIDTH'(1);
    end else if (!grant_c && fifo_pop_i && (credits_o != CNT_WIDTH'(DEPTH))) begin
      credits_d = credits_o + CNT_WIDTH'(1);
    end

    if ((fifo_pop_i && (credits_o == CNT_WIDTH'(DEPTH))) || (fifo_wr_en_o && fifo_full_i)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      ptr_q        <= PTR_W'(NUM_REQ - 1);
      gnt_o        <= '0;
      fifo_wr_en_o <= 1'b0;
      fifo_wdata_o <= '0;
      credits_o    <= CNT_WIDTH'(DEPTH);
      err_o        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_o        <= gnt_d;
      fifo_wr_en_o <= wr_en_d;
      fifo_wdata_o <= wdata_d;
      credits_o    <= credits_d;
      err_o        <= err_d;
    end
  end

  assign stall_o = (state_q == STALL);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned WIDTH     = 4;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);
  localparam int          N         = 4;
  localparam int          D         = 16;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ*WIDTH-1:0] wdata_i;
  logic [NUM_REQ-1:0]       gnt_o;
  logic                     fifo_full_i;
  logic                     fifo_pop_i;
  logic                     fifo_wr_en_o;
  logic [WIDTH-1:0]         fifo_wdata_o;
  logic [CNT_WIDTH-1:0]     credits_o;
  logic                     stall_o;
  logic                     err_o;

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .wdata_i(wdata_i), .gnt_o(gnt_o),
    .fifo_full_i(fifo_full_i), .fifo_pop_i(fifo_pop_i), .fifo_wr_en_o(fifo_wr_en_o),
    .fifo_wdata_o(fifo_wdata_o), .credits_o(credits_o), .stall_o(stall_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state: what the outputs should be after the last edge.
  logic [NUM_REQ-1:0] m_gnt;
  logic               m_wr;
  logic [WIDTH-1:0]   m_wdata;
  int                 m_credits;
  logic               m_stall;
  logic               m_err;
  int                 m_ptr;
  int                 occ;
  logic               force_full;
  logic [NUM_REQ-1:0] pend;
  logic [WIDTH-1:0]   dat [NUM_REQ];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Eligible requester closest (clockwise) after the last winner; requester 0 first when prioritised.
  function automatic int pick(input logic [NUM_REQ-1:0] elig);
    int best   = -1;
    int best_d = N + 1;
`ifdef FIFO_ARB_PRIO_EN
    if (elig[0]) return 0;
`endif
    for (int i = 0; i < N; i++) begin
      int d;
`ifdef FIFO_ARB_PRIO_EN
      if (i == 0) continue;
`endif
      d = (i - m_ptr - 1 + 2 * N) % N;
      if (elig[i] && d < best_d) begin
        best_d = d;
        best   = i;
      end
    end
    return best;
  endfunction

  task automatic drive_data();
    for (int k = 0; k < N; k++) wdata_i[k*WIDTH +: WIDTH] = dat[k];
  endtask

  task automatic compare_all(input string where);
    check({where, ".gnt"},     32'(gnt_o),        32'(m_gnt));
    check({where, ".wr_en"},   32'(fifo_wr_en_o), 32'(m_wr));
    check({where, ".wdata"},   32'(fifo_wdata_o), 32'(m_wdata));
    check({where, ".credits"}, 32'(credits_o),    32'(m_credits));
    check({where, ".stall"},   32'(stall_o),      32'(m_stall));
    check({where, ".err"},     32'(err_o),        32'(m_err));
  endtask

  // Advance the model over the coming edge using the inputs currently applied, then clock and compare.
  task automatic tick(input string where);
    logic [NUM_REQ-1:0] elig;
    logic ok;
    int   w;
    elig = req_i & ~m_gnt;
    ok   = (elig != '0) && (m_credits > 0) && !fifo_full_i;
    if ((fifo_pop_i && m_credits == D) || (m_wr && fifo_full_i)) m_err = 1'b1;
    occ = occ + (m_wr ? 1 : 0) - (fifo_pop_i ? 1 : 0);
    if (occ < 0) occ = 0;
    m_credits = m_credits - (ok ? 1 : 0) + (fifo_pop_i ? 1 : 0);
    if (m_credits > D) m_credits = D;
    m_stall = !ok && (elig != '0);
    m_gnt   = '0;
    m_wr    = ok;
    if (ok) begin
      w        = pick(elig);
      m_gnt[w] = 1'b1;
      m_wdata  = wdata_i[w*WIDTH +: WIDTH];
`ifdef FIFO_ARB_PRIO_EN
      if (w != 0) m_ptr = w;
`else
      m_ptr = w;
`endif
    end
    @(posedge clk_i);
    #1;
    compare_all(where);
    fifo_full_i = force_full || (occ >= D);
  endtask

  task automatic reset_dut();
    rst_i       = 1'b0;
    req_i       = '0;
    fifo_pop_i  = 1'b0;
    force_full  = 1'b0;
    fifo_full_i = 1'b0;
    pend        = '0;
    #1;
    m_gnt = '0; m_wr = 1'b0; m_wdata = '0; m_credits = D;
    m_stall = 1'b0; m_err = 1'b0; m_ptr = N - 1; occ = 0;
    compare_all("reset");
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  logic [NUM_REQ-1:0] exp_gnt [6];
  logic [WIDTH-1:0]   exp_dat [5];
  int cnt;

  initial begin
    rst_i = 1'b1; req_i = '0; wdata_i = '0; fifo_pop_i = 1'b0; fifo_full_i = 1'b0; force_full = 1'b0;
    for (int k = 0; k < N; k++) dat[k] = WIDTH'(k + 1);
    drive_data();
    #2;
    reset_dut();
    check("rst_credits", 32'(credits_o), 32'(D));

    // First grants after reset with all four requesting.
    req_i = 4'b1111;
`ifdef FIFO_ARB_PRIO_EN
    exp_gnt = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b0001, 4'b1000};
    exp_dat = '{4'd1, 4'd2, 4'd1, 4'd3, 4'd1};
`else
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    exp_dat = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
`endif
    for (int i = 0; i < 5; i++) begin
      tick("first");
      check("first_gnt",   32'(gnt_o),        32'(exp_gnt[i]));
      check("first_wdata", 32'(fifo_wdata_o), 32'(exp_dat[i]));
      check("first_wr_en", 32'(fifo_wr_en_o), 32'd1);
    end

    // Credit exhaustion with no pops.
    reset_dut();
    req_i = 4'b1111;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick("exhaust");
      if (fifo_wr_en_o) cnt++;
    end
    check("exhaust_writes",  32'(cnt),       32'd16);
    check("exhaust_credits", 32'(credits_o), 32'd0);
    check("exhaust_stall",   32'(stall_o),   32'd1);
    check("exhaust_err",     32'(err_o),     32'd0);

    // One pop releases exactly one grant.
    fifo_pop_i = 1'b1;
    tick("release_pop");
    fifo_pop_i = 1'b0;
    check("release_credits1", 32'(credits_o), 32'd1);
    tick("release_grant");
    check("release_wr_en",    32'(fifo_wr_en_o), 32'd1);
    check("release_credits0", 32'(credits_o),    32'd0);
    tick("release_stall");
    check("release_restall",  32'(stall_o),      32'd1);
    check("release_nowr",     32'(fifo_wr_en_o), 32'd0);

    // Grant and pop on the same edge leave credits unchanged.
    reset_dut();
    req_i = 4'b1111;
    for (int i = 0; i < 8; i++) tick("fill8");
    check("fill8_credits", 32'(credits_o), 32'd8);
    fifo_pop_i = 1'b1;
    tick("both");
    fifo_pop_i = 1'b0;
    check("both_credits", 32'(credits_o),    32'd8);
    check("both_wr_en",   32'(fifo_wr_en_o), 32'd1);

    // Single requester gets every other cycle; then reset lands mid-grant.
    reset_dut();
    req_i = 4'b0100;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick("single");
      if (gnt_o[2]) cnt++;
    end
    check("single_grants", 32'(cnt), 32'd3);
    tick("single_more");
    check("single_gnt", 32'(gnt_o), 32'b0100);
    #2;
    reset_dut();
    check("midrst_credits", 32'(credits_o),    32'd16);
    check("midrst_wr_en",   32'(fifo_wr_en_o), 32'd0);

    // Full flag blocks grants without raising an error.
    req_i = 4'b0001;
    force_full = 1'b1; fifo_full_i = 1'b1;
    tick("full_block");
    tick("full_block");
    check("full_nowr",  32'(fifo_wr_en_o), 32'd0);
    check("full_stall", 32'(stall_o),      32'd1);
    force_full = 1'b0; fifo_full_i = 1'b0;
    tick("full_release");
    check("full_release_gnt", 32'(gnt_o), 32'b0001);

    // Pop at full credits sets a sticky error.
    reset_dut();
    fifo_pop_i = 1'b1;
    tick("err_pop");
    fifo_pop_i = 1'b0;
    check("err_set", 32'(err_o), 32'd1);
    for (int i = 0; i < 3; i++) tick("err_hold");
    check("err_sticky", 32'(err_o), 32'd1);

    // Requesters 0, 1 and 3 held.
    reset_dut();
    req_i = 4'b1011;
`ifdef FIFO_ARB_PRIO_EN
    exp_gnt = '{4'b0001, 4'b0010, 4'b0001, 4'b1000, 4'b0001, 4'b0010};
`else
    exp_gnt = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
`endif
    for (int i = 0; i < 6; i++) begin
      tick("mix");
      check("mix_gnt", 32'(gnt_o), 32'(exp_gnt[i]));
    end

    // Randomized traffic: requesters hold until granted, occasionally abandon; pops vary by phase.
    for (int phase = 0; phase < 3; phase++) begin
      reset_dut();
      for (int c = 0; c < 1500; c++) begin
        for (int k = 0; k < N; k++) begin
          if (m_gnt[k]) pend[k] = 1'b0;
          if (!pend[k]) begin
            if ($urandom_range(0, 2) == 0) begin
              pend[k] = 1'b1;
              dat[k]  = WIDTH'($urandom);
            end
          end else if ($urandom_range(0, 31) == 0) begin
            pend[k] = 1'b0;
          end
        end
        req_i = pend;
        drive_data();
        case (phase)
          0:       fifo_pop_i = (occ > 0) && ($urandom_range(0, 5) == 0);
          1:       fifo_pop_i = (occ > 0) && ($urandom_range(0, 3) != 0);
          default: fifo_pop_i = (occ > 0) && ($urandom_range(0, 1) == 0);
        endcase
        tick("rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one synchronous FIFO (DEPTH x WIDTH) among NUM_REQ producers.
- Owns flow control: keeps a local credit count of free FIFO slots, so it never writes into a full FIFO, even though the FIFO's full flag lags by one cycle.
- Sits between producer blocks and the FIFO's wr_en/wdata inputs; observes the FIFO's effective pops.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 4, data width per requester and FIFO word width
- DEPTH, 16, FIFO depth; initial and maximum credit count
- CNT_WIDTH, $clog2(DEPTH+1), credit counter width

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous, active-low reset
- req_i  input  NUM_REQ  per-requester write request; held with data until granted
- wdata_i  input  NUM_REQ*WIDTH  packed requester data; slice k = [k*WIDTH +: WIDTH]
- gnt_o  output  NUM_REQ  one-hot grant, registered, 1-cycle pulse
- fifo_full_i  input  1  FIFO full flag, used only as a safety check
- fifo_pop_i  input  1  effective FIFO read this cycle (rd_en & !empty)
- fifo_wr_en_o  output  1  registered write strobe to FIFO
- fifo_wdata_o  output  WIDTH  registered write data to FIFO
- credits_o  output  CNT_WIDTH  current free-slot count
- stall_o  output  1  high in STALL state
- err_o  output  1  sticky protocol/overflow error

Behaviour:
- Reset (rst_i=0, async, any time, including mid-transfer): gnt_o=0, fifo_wr_en_o=0, fifo_wdata_o=0, credits_o=DEPTH, stall_o=0, err_o=0, state=IDLE, RR pointer=NUM_REQ-1 so requester 0 wins first. A grant in flight is dropped and does not count as a write.
- Eligible set at each edge: req_i & ~gnt_o. The just-granted requester is masked for one cycle, so a requester that drops or updates req/data on its grant edge is never granted twice for one word.
- Arbitration: search starts at pointer+1 mod NUM_REQ, lowest index after that wins. The pointer updates to the winner only when a grant issues.
- Grant condition at edge: eligible set non-empty AND credits_o>0 AND fifo_full_i=0.
  - When met: next cycle gnt_o[w]=1, fifo_wr_en_o=1, fifo_wdata_o=wdata_i slice w.
  - Otherwise: gnt_o=0, fifo_wr_en_o=0, fifo_wdata_o holds its last value.
- Latency: req sampled at edge k -> gnt/wr_en high in cycle k..k+1 -> FIFO captures at edge k+1. Sustained throughput is 1 word/cycle when at least 2 requesters are active; a single requester gets every other cycle.
- Credits, updated each edge:
  - -1 for a grant issued at that edge.
  - +1 for fifo_pop_i.
  - Both or neither: unchanged.
  - Saturates at 0 and DEPTH.
  - A pop while credits_o=DEPTH sets err_o.
- FSM:
  - IDLE: no eligible request. Goes to GRANT if the grant condition is met, to STALL if requests exist but credits_o=0 or fifo_full_i=1.
  - GRANT: a grant issued this cycle. Re-evaluates each edge: GRANT / STALL / IDLE.
  - STALL: stall_o=1, no grants. Goes to GRANT on the first edge where credits>0 and full=0 with an eligible request; goes to IDLE if requests vanish.
- err_o (sticky until reset) also sets if fifo_wr_en_o=1 while fifo_full_i=1, or on a pop at credits_o=DEPTH.
- Requesters must hold req_i and their data stable until grant. A request dropped before grant is legal; it is simply not serviced.

Optional Feature:
- FIFO_ARB_PRIO_EN defined:
  - requester 0 has strict priority; whenever it is eligible it wins regardless of the pointer.
  - requesters 1..NUM_REQ-1 round-robin among themselves.
  - a requester-0 grant does not move the pointer.
- Undefined: pure round-robin over all NUM_REQ requesters as above.

Test Plan:
- Reset/first grant: release rst_i, req_i=4'b1111, data k=k+1 -> gnt_o order 0001,0010,0100,1000,0001; fifo_wdata_o 1,2,3,4,1; wr_en high every cycle.
- Credit exhaustion: DEPTH=16, continuous requests, no pops -> exactly 16 writes, credits_o 16->0, stall_o=1, fifo_wr_en_o never high with fifo_full_i=1, err_o=0.
- Stall release: from credits 0, one fifo_pop_i pulse -> credits 1, exactly one grant next cycle, back to STALL.
- Simultaneous write and pop: credits_o=8, grant and pop on the same edge -> credits_o stays 8.
- Single requester: only req_i[2] held high for 6 cycles -> gnt_o[2] on alternate cycles (3 grants); reset asserted mid-grant -> all outputs 0 immediately, credits_o=16.
- Error/priority: pop at credits_o=16 -> err_o=1 sticky. With FIFO_ARB_PRIO_EN defined and req_i=4'b1011 held -> requester 0 granted every other cycle, requesters 1 and 3 alternate in the gaps.
